// File: rtl/seq_det_pkg.sv
// Shared types and sizing helpers for the serial sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    localparam int PAT_MAX_DEFAULT = 8;

    function automatic int len_width(input int pat_max);
        return $clog2(pat_max) + 1;
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift register, fill counter and length-masked comparator for one matching engine.
module seq_match_core
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEFAULT,
    parameter int LEN_W   = len_width(PAT_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               x,
    input  logic [PAT_MAX-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [PAT_MAX-2:0] hist;
    logic [LEN_W-1:0]   fill;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] mask;

    // The incoming bit completes the window, so a hit is reported in the sampling cycle.
    always_comb begin
        window = {hist, x};
        mask   = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift_en
              && (fill >= (len - LEN_W'(1)))
              && ((window & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (shift_en) begin
            hist <= window[PAT_MAX-2:0];
            if (fill < len) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller for programmable serial sequence detection: config handshake, arm/run/stop FSM,
// saturating match counter and threshold-based completion.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int PAT_MAX = PAT_MAX_DEFAULT,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_width(PAT_MAX)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_threshold,
    output logic               cfg_err,
    input  logic               start,
    input  logic               abort,
    input  logic               x,
    input  logic               x_valid,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [PAT_MAX-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   threshold_q;
    logic               cfg_loaded;

    logic               cfg_hs;
    logic               len_ok;
    logic               cfg_take;
    logic               start_ok;
    logic               shift_en;
    logic               hit;
    logic [CNT_W-1:0]   count_next;

    // Abort suppresses shifting so a completing bit in the abort cycle is never counted.
    always_comb begin
        cfg_hs     = cfg_valid && cfg_ready;
        len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_MAX));
        cfg_take   = cfg_hs && len_ok;
        start_ok   = start && cfg_ready && (cfg_loaded || cfg_take);
        shift_en   = (state == ARMED) && x_valid && !abort;
        count_next = (match_count == '1) ? match_count : match_count + CNT_W'(1);
    end

    seq_match_core #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .shift_en (shift_en),
        .x        (x),
        .pattern  (pattern_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pattern_q   <= '0;
            len_q       <= '0;
            threshold_q <= '0;
            cfg_loaded  <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            match   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (cfg_take) begin
                        pattern_q   <= cfg_pattern;
                        len_q       <= cfg_len;
                        threshold_q <= cfg_threshold;
                        cfg_loaded  <= 1'b1;
                    end else if (cfg_hs) begin
                        cfg_err <= 1'b1;
                    end
                    if (start_ok) begin
                        state       <= ARMED;
                        cfg_ready   <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        match_count <= '0;
                    end else if ((state == DONE) && abort) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (hit) begin
                        match       <= 1'b1;
                        match_count <= count_next;
                        if ((threshold_q != '0) && (count_next == threshold_q)) begin
                            state     <= DONE;
                            cfg_ready <= 1'b1;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl with hand-computed expectations.
module tb_seq_detect_ctrl;

    localparam int PAT_MAX = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic [CNT_W-1:0]   cfg_threshold;
    logic               cfg_err;
    logic               start;
    logic               abort;
    logic               x;
    logic               x_valid;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;

    seq_detect_ctrl #(
        .PAT_MAX (PAT_MAX),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_pattern   (cfg_pattern),
        .cfg_len       (cfg_len),
        .cfg_threshold (cfg_threshold),
        .cfg_err       (cfg_err),
        .start         (start),
        .abort         (abort),
        .x             (x),
        .x_valid       (x_valid),
        .match         (match),
        .match_count   (match_count),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cv, input logic [PAT_MAX-1:0] pat, input logic [LEN_W-1:0] len,
                                 input logic [CNT_W-1:0] thr, input logic st, input logic ab,
                                 input logic xb, input logic xv);
        cfg_valid     = cv;
        cfg_pattern   = pat;
        cfg_len       = len;
        cfg_threshold = thr;
        start         = st;
        abort         = ab;
        x             = xb;
        x_valid       = xv;
        tick();
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic configure(input logic [PAT_MAX-1:0] pat, input logic [LEN_W-1:0] len, input logic [CNT_W-1:0] thr);
        applyStimulus(1'b1, pat, len, thr, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic armIt();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic abortIt();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic feedBit(input logic b);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, b, 1'b1);
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic s1[7]    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic e1[7]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic s2[6]    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic e2[6]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic done2[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   cnt2[6]  = '{0, 0, 1, 1, 2, 2};

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_threshold = '0;
        start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
        #3;
        checkOutput("reset cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset match_count", 32'(match_count), 32'd0);
        checkOutput("reset cfg_err", 32'(cfg_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Test 1: overlapping free-run matches of 0110
        configure(8'b0000_0110, 4'd4, 8'd0);
        checkOutput("t1 cfg_err legal", 32'(cfg_err), 32'd0);
        armIt();
        checkOutput("t1 busy armed", 32'(busy), 32'd1);
        checkOutput("t1 cfg_ready armed", 32'(cfg_ready), 32'd0);
        for (int i = 0; i < 7; i++) begin
            feedBit(s1[i]);
            checkOutput($sformatf("t1 match bit%0d", i + 1), 32'(match), 32'(e1[i]));
        end
        checkOutput("t1 count", 32'(match_count), 32'd2);
        checkOutput("t1 busy", 32'(busy), 32'd1);
        checkOutput("t1 done", 32'(done), 32'd0);
        abortIt();
        checkOutput("t1 abort busy", 32'(busy), 32'd0);
        checkOutput("t1 abort count kept", 32'(match_count), 32'd2);
        checkOutput("t1 abort cfg_ready", 32'(cfg_ready), 32'd1);

        // Test 2: threshold of two reaches DONE, later bits ignored
        configure(8'b0000_0101, 4'd3, 8'd2);
        armIt();
        checkOutput("t2 count cleared", 32'(match_count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            feedBit(s2[i]);
            checkOutput($sformatf("t2 match bit%0d", i + 1), 32'(match), 32'(e2[i]));
            checkOutput($sformatf("t2 done bit%0d", i + 1), 32'(done), 32'(done2[i]));
            checkOutput($sformatf("t2 busy bit%0d", i + 1), 32'(busy), 32'(!done2[i]));
            checkOutput($sformatf("t2 count bit%0d", i + 1), 32'(match_count), 32'(cnt2[i]));
        end
        checkOutput("t2 cfg_ready in done", 32'(cfg_ready), 32'd1);
        abortIt();
        checkOutput("t2 abort clears done", 32'(done), 32'd0);

        // Test 3: illegal lengths rejected, start without config ignored
        resetPulse();
        configure(8'b0000_0011, 4'd0, 8'd0);
        checkOutput("t3 err len0", 32'(cfg_err), 32'd1);
        idle();
        checkOutput("t3 err pulse ends", 32'(cfg_err), 32'd0);
        configure(8'b0000_0011, 4'd9, 8'd0);
        checkOutput("t3 err len9", 32'(cfg_err), 32'd1);
        armIt();
        checkOutput("t3 start ignored", 32'(busy), 32'd0);
        checkOutput("t3 cfg_err cleared", 32'(cfg_err), 32'd0);

        // Test 4: fill guard on all-zero pattern
        configure(8'b0000_0000, 4'd3, 8'd0);
        armIt();
        feedBit(1'b0);
        checkOutput("t4 guard bit1", 32'(match), 32'd0);
        feedBit(1'b0);
        checkOutput("t4 guard bit2", 32'(match), 32'd0);
        feedBit(1'b0);
        checkOutput("t4 match bit3", 32'(match), 32'd1);
        feedBit(1'b0);
        checkOutput("t4 match bit4", 32'(match), 32'd1);
        checkOutput("t4 count", 32'(match_count), 32'd2);

        // Test 5: abort beats a completing bit
        applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("t5 no match", 32'(match), 32'd0);
        checkOutput("t5 count kept", 32'(match_count), 32'd2);
        checkOutput("t5 busy", 32'(busy), 32'd0);
        checkOutput("t5 cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("t5 done", 32'(done), 32'd0);

        // Test 6: asynchronous reset mid-ARMED
        configure(8'b0000_0110, 4'd4, 8'd0);
        armIt();
        feedBit(1'b0); feedBit(1'b1); feedBit(1'b1); feedBit(1'b0);
        checkOutput("t6 pre-reset count", 32'(match_count), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6 async busy", 32'(busy), 32'd0);
        checkOutput("t6 async cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("t6 async count", 32'(match_count), 32'd0);
        checkOutput("t6 async match", 32'(match), 32'd0);
        tick();
        rst = 1'b0;
        armIt();
        checkOutput("t6 start ignored", 32'(busy), 32'd0);

        // Test 7: start together with a new config, single-bit pattern, saturation
        configure(8'b0000_0110, 4'd4, 8'd0);
        applyStimulus(1'b1, 8'b0000_0001, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t7 armed", 32'(busy), 32'd1);
        feedBit(1'b1);
        checkOutput("t7 new cfg match", 32'(match), 32'd1);
        for (int i = 0; i < 259; i++) begin
            feedBit(1'b1);
        end
        checkOutput("t7 saturated count", 32'(match_count), 32'd255);
        checkOutput("t7 match at saturation", 32'(match), 32'd1);
        checkOutput("t7 free-run busy", 32'(busy), 32'd1);
        abortIt();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
